// File: rtl/sms_tal_arbiter_if.sv
// Handshake bundle between the TAL arbiter, its requesters and the shared
// SMS_CARD_TAL pulse-latch card.
//   slave  : the arbiter side (drives grants, acks and the card inputs)
//   master : the requester/card side (drives req and the card's d output)
interface sms_tal_arbiter_if #(
   parameter int N_REQ = 4
);
   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] ack;
   logic [N_REQ-1:0] err;
   logic [GW-1:0]    grant_id;
   logic             busy;
   logic             tal_b;
   logic             tal_c;
   logic             tal_d;

   modport slave (
      input  req, tal_d,
      output ack, err, grant_id, busy, tal_b, tal_c
   );

   modport master (
      output req, tal_d,
      input  ack, err, grant_id, busy, tal_b, tal_c
   );
endinterface

// File: rtl/sms_tal_arbiter.sv
// Round-robin arbiter/sequencer sharing one TAL pulse-latch card among
// N_REQ requesters. The granted requester gets a PULSE_W-cycle set pulse on
// tal_b with the gate tal_c held, then the block waits up to TIMEOUT cycles
// for the card's d output and reports ack or err to that requester.
//
// Optional build macro TAL_SYNC_EN: when defined, tal_d passes through a
// 2-flop synchronizer before the FSM sees it (tal_d is asynchronous to
// SYSCLOCK on real hardware). When undefined, tal_d is sampled directly.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | card free; requests evaluated round-robin from grant_id+1
// PULSE   | tal_b=1, tal_c=1 for PULSE_W cycles
// WAIT_D  | tal_c=1, counting cycles until d seen or TIMEOUT reached
// RELEASE | one cycle with card inputs low, ack/err pulse visible
module sms_tal_arbiter #(
   parameter int N_REQ   = 4,
   parameter int PULSE_W = 2,
   parameter int TIMEOUT = 15
) (
   input logic             SYSCLOCK,
   input logic             RESET_N,
   sms_tal_arbiter_if.slave bus
);

   localparam int GW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int PCW = 4;
   localparam int WCW = 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PULSE   = 2'd1,
      S_WAIT_D  = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t           state_q;
   logic [N_REQ-1:0] ack_q;
   logic [N_REQ-1:0] err_q;
   logic [GW-1:0]    grant_id_q;
   logic             busy_q;
   logic             tal_b_q;
   logic             tal_c_q;
   logic [PCW-1:0]   pulse_cnt_q;
   logic [WCW-1:0]   wait_cnt_q;

   logic             d_s;
   logic [GW-1:0]    pick_id_d;
   logic             pick_vld_d;
   int               best_c;
   int               dist_c;

`ifdef TAL_SYNC_EN
   logic [1:0]       d_sync_q;

   // Two-flop synchronizer for the card's asynchronous d output.
   always_ff @(posedge SYSCLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         d_sync_q <= 2'b00;
      end else begin
         d_sync_q <= {d_sync_q[0], bus.tal_d};
      end
   end

   assign d_s = d_sync_q[1];
`else
   assign d_s = bus.tal_d;
`endif

   // Round-robin pick: nearest set request strictly after grant_id, wrapping;
   // the last granted requester is only chosen again when it is the sole one.
   always_comb begin
      pick_vld_d = 1'b0;
      pick_id_d  = grant_id_q;
      best_c     = N_REQ;
      dist_c     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         dist_c = i - int'(grant_id_q) - 1;
         if (dist_c < 0) begin
            dist_c = dist_c + N_REQ;
         end
         if (((bus.req >> i) & N_REQ'(1)) != '0 && dist_c < best_c) begin
            best_c     = dist_c;
            pick_id_d  = GW'(i);
            pick_vld_d = 1'b1;
         end
      end
   end

   // Sequencer FSM with all outputs registered; ack/err default low so they
   // only ever pulse for the single cycle spent in RELEASE.
   always_ff @(posedge SYSCLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= S_IDLE;
         ack_q       <= '0;
         err_q       <= '0;
         grant_id_q  <= GW'(N_REQ - 1);
         busy_q      <= 1'b0;
         tal_b_q     <= 1'b0;
         tal_c_q     <= 1'b0;
         pulse_cnt_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         ack_q <= '0;
         err_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (pick_vld_d) begin
                  grant_id_q  <= pick_id_d;
                  state_q     <= S_PULSE;
                  busy_q      <= 1'b1;
                  tal_b_q     <= 1'b1;
                  tal_c_q     <= 1'b1;
                  pulse_cnt_q <= PCW'(PULSE_W - 1);
               end
            end
            S_PULSE: begin
               if (pulse_cnt_q == '0) begin
                  state_q    <= S_WAIT_D;
                  tal_b_q    <= 1'b0;
                  wait_cnt_q <= '0;
               end else begin
                  pulse_cnt_q <= pulse_cnt_q - PCW'(1);
               end
            end
            S_WAIT_D: begin
               // d is checked first so it wins over a coincident timeout
               if (d_s) begin
                  ack_q   <= N_REQ'(1) << grant_id_q;
                  state_q <= S_RELEASE;
                  tal_c_q <= 1'b0;
               end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
                  err_q   <= N_REQ'(1) << grant_id_q;
                  state_q <= S_RELEASE;
                  tal_c_q <= 1'b0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WCW'(1);
               end
            end
            S_RELEASE: begin
               state_q    <= S_IDLE;
               busy_q     <= 1'b0;
               wait_cnt_q <= '0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               tal_b_q <= 1'b0;
               tal_c_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ack      = ack_q;
   assign bus.err      = err_q;
   assign bus.grant_id = grant_id_q;
   assign bus.busy     = busy_q;
   assign bus.tal_b    = tal_b_q;
   assign bus.tal_c    = tal_c_q;

endmodule

// File: tb/tb_sms_tal_arbiter.sv
// Scoreboard bench for sms_tal_arbiter: each service pushes its expected
// requester, ack/err pattern and grant-to-response latency; a negedge
// monitor pops and compares whenever ack or err pulses.
module tb_sms_tal_arbiter;

   localparam int N       = 4;
   localparam int PULSE_W = 2;
   localparam int TIMEOUT = 15;
`ifdef TAL_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif

   typedef struct {
      int           id;
      logic [N-1:0] ack;
      logic [N-1:0] err;
      int           lat;
   } exp_t;

   logic clk;
   logic rst_n;
   sms_tal_arbiter_if #(.N_REQ(N)) bus();

   sms_tal_arbiter #(
      .N_REQ  (N),
      .PULSE_W(PULSE_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .SYSCLOCK(clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_resp = 0;
   int   cyc    = 0;
   int   grant_cyc = 0;
   int   tb_cnt = 0;
   bit   busy_prev = 0;
   bit   chk_busy_next = 0;
   int   model_ptr = N - 1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (obs === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int off = 1; off <= N; off++) begin
         int i;
         i = (last + off) % N;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic wait_neg();
      @(negedge clk);
      #1;
   endtask

   // Response monitor: pops the scoreboard on every ack/err pulse.
   always @(negedge clk) begin
      if (!rst_n) begin
         tb_cnt        = 0;
         busy_prev     = 0;
         chk_busy_next = 0;
      end else begin
         if (bus.busy && !busy_prev) grant_cyc = cyc;
         if (chk_busy_next) begin
            chk("busy_after_resp", bus.busy, 0);
            chk_busy_next = 0;
         end
         if (bus.tal_b) begin
            tb_cnt = tb_cnt + 1;
         end else if (tb_cnt != 0) begin
            chk("tal_b_width", tb_cnt, PULSE_W);
            tb_cnt = 0;
         end
         if ((bus.ack | bus.err) != '0) begin
            n_resp = n_resp + 1;
            if (sb_q.size() == 0) begin
               chk("unexpected_resp", {bus.ack, bus.err}, 0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("resp_grant_id", bus.grant_id, mon_e.id);
               chk("resp_ack", bus.ack, mon_e.ack);
               chk("resp_err", bus.err, mon_e.err);
               chk("resp_latency", cyc - grant_cyc, mon_e.lat);
               chk("release_gate", {bus.tal_b, bus.tal_c, bus.busy}, 3'b001);
               chk_busy_next = 1;
            end
         end
         busy_prev = bus.busy;
      end
   end

   // One service: dly<0 means d never comes; otherwise d rises dly edges
   // after WAIT_D is entered. hold keeps req up afterwards, drop releases
   // req right after the grant.
   task automatic run_one(input logic [N-1:0] r, input int dly, input bit hold, input bit drop);
      exp_t         e;
      logic [N-1:0] one;
      int           k;
      bit           is_err;
      int           n0;
      bit           ok;
      one    = 1;
      e.id   = rr_pick(r, model_ptr);
      model_ptr = e.id;
      k      = dly + 1 + SYNC;
      is_err = (dly < 0) || (k > TIMEOUT);
      e.ack  = is_err ? '0 : (one << e.id);
      e.err  = is_err ? (one << e.id) : '0;
      e.lat  = is_err ? (PULSE_W + TIMEOUT) : (PULSE_W + k);
      sb_q.push_back(e);
      n0 = n_resp;
      bus.req = r;

      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin wait_neg(); ok = bus.busy; end
      chk("grant_seen", bus.busy, 1);
      chk("pulse_start", {bus.tal_b, bus.tal_c}, 2'b11);
      if (drop) bus.req = '0;

      ok = 0;
      for (int i = 0; i < PULSE_W + 5 && !ok; i++) begin wait_neg(); ok = !bus.tal_b; end
      chk("wait_gate", {bus.tal_b, bus.tal_c}, 2'b01);

      if (dly >= 0) begin
         repeat (dly) @(posedge clk);
         #1 bus.tal_d = 1'b1;
      end

      ok = 0;
      for (int i = 0; i < TIMEOUT + 10 && !ok; i++) begin wait_neg(); ok = (n_resp != n0); end
      chk("resp_count", n_resp - n0, 1);
      bus.tal_d = 1'b0;
      if (!hold) bus.req = '0;

      ok = 0;
      for (int i = 0; i < 5 && !ok; i++) begin wait_neg(); ok = !bus.busy; end
      chk("idle_again", bus.busy, 0);
   endtask

   initial begin
      bit ok;
      int n0;
      rst_n     = 1'b0;
      bus.req   = '0;
      bus.tal_d = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      wait_neg();
      chk("rst_ack", bus.ack, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_tal", {bus.tal_b, bus.tal_c}, 2'b00);
      chk("rst_grant_id", bus.grant_id, N - 1);
      rst_n = 1'b1;
      repeat (3) wait_neg();

      // first grant after reset goes to requester 0, then simple services
      run_one(4'b0001, 0, 0, 0);
      run_one(4'b0100, 1, 0, 0);
      repeat (4) wait_neg();

      // all requesters held: round-robin rotation with wrap
      for (int g = 0; g < 5; g++) run_one(4'b1111, 2, 1, 0);
      bus.req = '0;
      repeat (3) wait_neg();

      // timeout with d never arriving
      run_one(4'b0010, -1, 0, 0);
      // d on the TIMEOUT-th WAIT_D edge: ack wins
      run_one(4'b1000, TIMEOUT - 1 - SYNC, 0, 0);
      // d one edge too late: err
      run_one(4'b0001, TIMEOUT - SYNC, 0, 0);
      // requester drops req while granted: service still completes
      run_one(4'b0110, 3, 0, 1);
      // pending lower-priority requests
      run_one(4'b1001, 0, 0, 0);
      repeat (2) wait_neg();

      // asynchronous reset in the middle of WAIT_D
      bus.req = 4'b0010;
      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin wait_neg(); ok = bus.busy; end
      for (int i = 0; i < PULSE_W + 5 && bus.tal_b; i++) wait_neg();
      repeat (3) wait_neg();
      chk("abort_in_wait", {bus.tal_b, bus.tal_c, bus.busy}, 3'b011);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_tal_c", bus.tal_c, 0);
      chk("abort_grant_id", bus.grant_id, N - 1);
      chk("abort_resp", {bus.ack, bus.err}, 0);
      bus.req = '0;
      model_ptr = N - 1;
      repeat (2) wait_neg();
      rst_n = 1'b1;
      n0 = n_resp;
      repeat (TIMEOUT + 5) wait_neg();
      chk("no_resp_after_abort", n_resp - n0, 0);
      chk("idle_after_abort", bus.busy, 0);

      // priority restarts at requester 0 after reset
      run_one(4'b1111, 0, 0, 0);

      repeat (3) wait_neg();
      chk("sb_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench time limit");
   end

endmodule

// File: doc/sms_tal_arbiter.md
# sms_tal_arbiter

Round-robin arbiter and sequencer that shares one TAL pulse-latch card among `N_REQ` requesters. It grants one requester at a time and drives the card's gate (`c`) and set (`b`) inputs for a fixed pulse width. It then waits for the card's `d` output, reports completion or timeout to the granted requester, and releases the card. It sits between the processor timing/control logic and a shared `SMS_CARD_TAL` instance.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `PULSE_W`, default 2: cycles `tal_b` is held high (1..15).
- `TIMEOUT`, default 15: `WAIT_D` cycles before declaring failure (1..255).
- `SYSCLOCK`  in  1: system clock, rising edge.
- `RESET_N`  in  1: asynchronous, active-low reset.
- `req`  in  N_REQ: level request. Must be held until `ack` or `err`.
- `ack`  out  N_REQ: one-cycle pulse to the granted requester when `d` is seen.
- `err`  out  N_REQ: one-cycle pulse to the granted requester on timeout.
- `grant_id`  out  $clog2(N_REQ): index of the current or last granted requester.
- `busy`  out  1: high in every state except `IDLE`.
- `tal_b`  out  1: set pulse to the card's `b` input.
- `tal_c`  out  1: gate to the card's `c` input.
- `tal_d`  in  1: card output `d`, asynchronous to `SYSCLOCK`.

## Operation
- All outputs are registered.
- Reset values: `ack`=0, `err`=0, `grant_id`=N_REQ-1 (so requester 0 has first priority), `busy`=0, `tal_b`=0, `tal_c`=0, state=`IDLE`, counters=0.
- States: `IDLE`, `PULSE`, `WAIT_D`, `RELEASE`.
- `IDLE` with any `req` bit set:
  - Pick the first set bit searching upward from `grant_id`+1, wrapping modulo N_REQ.
  - Latch it into `grant_id`.
  - Go to `PULSE`, with `tal_c`=1 and `tal_b`=1.
- `IDLE` with no `req` bit set: stay in `IDLE`.
- `PULSE`:
  - Hold `tal_b`=1 and `tal_c`=1 for exactly `PULSE_W` cycles.
  - Then go to `WAIT_D` with `tal_b`=0 and `tal_c`=1, and clear the wait counter.
- `WAIT_D`: the wait counter increments every cycle.
  - Sampled `d`=1: go to `RELEASE` and pulse `ack[grant_id]`.
  - Counter reaches `TIMEOUT` with `d` never seen: go to `RELEASE` and pulse `err[grant_id]`.
  - `d` and timeout on the same edge: `d` wins, so `ack` pulses and `err` does not.
- `RELEASE`: one cycle with `tal_c`=0, `tal_b`=0, then return to `IDLE`.
  - A request may be re-granted on the edge after `RELEASE`.
  - Leaving `RELEASE` does not wait for `tal_d` to fall.
- A requester dropping `req` while granted is ignored: the cycle completes and its `ack`/`err` still pulses.
- New requests arriving while busy wait in `req`. They are evaluated only in `IDLE`.
- `ack` and `err` are one-hot or zero. They are never both high.
- `RESET_N` low at any point, including mid-`PULSE` or mid-`WAIT_D`, immediately forces every output to its reset value. No `ack`/`err` is emitted for the aborted service.

## Timing
- Edge E0 samples `req` in `IDLE`. From E0 to E0+PULSE_W: `tal_b`=1, `busy`=1, `grant_id` valid.
- `WAIT_D` is entered at edge E0+PULSE_W.
- With sync: `tal_d` rising before edge Ek is seen in `WAIT_D` at Ek+2. `ack` is high for the cycle after that edge (the `RELEASE` cycle).
- Best-case request-to-`ack` latency: PULSE_W+3 cycles with sync, PULSE_W+1 without.
- Timeout: `err` asserts in the cycle after the TIMEOUT-th `WAIT_D` edge.
- Back-to-back service cadence: PULSE_W + (wait cycles) + 2 cycles per grant.
- The round-robin pointer advances only on a grant. Idle cycles do not rotate it.

## Configuration
- `TAL_SYNC_EN` defined: `tal_d` passes through a 2-flop synchronizer before FSM use, adding 2 cycles of latency.
- `TAL_SYNC_EN` not defined: `tal_d` is sampled directly by the FSM. This is for benches driving `tal_d` synchronously to `SYSCLOCK`.
- The 2-cycle difference applies to `ack` latency only. Timeout is counted identically in both modes.

## Test plan
- Reset: hold `RESET_N`=0 for 3 cycles, release. All outputs are 0 and `grant_id`=3 (N_REQ=4); the first `req`=0001 is granted id 0.
- Single request, sync on, PULSE_W=2: `req`=0100 at E0, `tal_d` raised at E0+3. `tal_b` is high for 2 cycles, `grant_id`=2, one `ack`=0100 pulse at E0+6, `busy` falls 1 cycle later.
- Round-robin: `req`=1111 held, `tal_d` returns after each pulse. Grants go 0,1,2,3,0 and each `ack` is a single pulse.
- Timeout, TIMEOUT=15: `req`=0010 and `tal_d` held 0. `err`=0010 pulses after 15 `WAIT_D` cycles, then `RELEASE`, `IDLE`, and `ack` stays 0.
- Simultaneous `d` and timeout: `tal_d` arrives exactly on the 15th `WAIT_D` edge. `ack` pulses and `err` stays 0.
- Reset mid-`WAIT_D`: assert `RESET_N`=0 asynchronously. `tal_c`/`busy` drop without waiting for an edge, no `ack`/`err` pulses, and `grant_id`=N_REQ-1 (3 for N_REQ=4) after release.
